regfile_wr_2p: RTL and testbench

Dual-write-port, 32-entry by 32-bit architectural register file for the superscalar MIPS pipeline: the write side that the 32-to-1 read muxes select from. Each of two write ports decodes its 5-bit address to a one-hot enable and updates the addressed register on the rising clock edge. All 32 register values are driven out in parallel to the read-port muxes. Register 0 is hardwired to zero.

---
 rtl/regfile_wr_2p_pkg.sv | 7 +
 rtl/regfile_wr_2p_dec_5t32.sv | 10 +
 rtl/regfile_wr_2p.sv | 69 ++++++
 tb/tb_regfile_wr_2p.sv | 134 +++++++++++++
 4 files changed

// File: rtl/regfile_wr_2p_pkg.sv
// regfile_wr_2p_pkg: register-file constants shared with the read muxes and pipeline.
package regfile_wr_2p_pkg;
    localparam int REG_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/regfile_wr_2p_dec_5t32.sv
// dec_5t32: 5-to-32 one-hot decoder gated by an enable.
module dec_5t32
    import regfile_wr_2p_pkg::*;
(
    input  logic              en,
    input  logic [ADDR_W-1:0] a,
    output logic [NUM_REGS-1:0] y
);
    assign y = en ? (NUM_REGS'(1) << a) : '0;
endmodule

// File: rtl/regfile_wr_2p.sv
// regfile_wr_2p: dual-write-port 32x32 register file, port 1 wins collisions, r00 hardwired to zero.
module regfile_wr_2p
    import regfile_wr_2p_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [REG_W-1:0]  wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [REG_W-1:0]  wd1,
    output logic [REG_W-1:0]  r00, r01, r02, r03, r04, r05, r06, r07,
    output logic [REG_W-1:0]  r08, r09, r0A, r0B, r0C, r0D, r0E, r0F,
    output logic [REG_W-1:0]  r10, r11, r12, r13, r14, r15, r16, r17,
    output logic [REG_W-1:0]  r18, r19, r1A, r1B, r1C, r1D, r1E, r1F,
    output logic              wr_conflict
);
    logic [NUM_REGS-1:0] en0, en1;
    logic [REG_W-1:0] rf [1:NUM_REGS-1];

    dec_5t32 u_dec0 (.en(we0), .a(wa0), .y(en0));
    dec_5t32 u_dec1 (.en(we1), .a(wa1), .y(en1));

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        always_ff @(posedge clk or posedge rst)
            if (rst) rf[i] <= '0;
            else if (en1[i]) rf[i] <= wd1;
            else if (en0[i]) rf[i] <= wd0;
    end

    // One-hot enables overlap only on a shared address; an overlap at register 0 is not a conflict.
    always_ff @(posedge clk or posedge rst)
        if (rst) wr_conflict <= 1'b0;
        else wr_conflict <= (|(en0 & en1)) & ~en0[0];

    assign r00 = '0;
    assign r01 = rf[1];
    assign r02 = rf[2];
    assign r03 = rf[3];
    assign r04 = rf[4];
    assign r05 = rf[5];
    assign r06 = rf[6];
    assign r07 = rf[7];
    assign r08 = rf[8];
    assign r09 = rf[9];
    assign r0A = rf[10];
    assign r0B = rf[11];
    assign r0C = rf[12];
    assign r0D = rf[13];
    assign r0E = rf[14];
    assign r0F = rf[15];
    assign r10 = rf[16];
    assign r11 = rf[17];
    assign r12 = rf[18];
    assign r13 = rf[19];
    assign r14 = rf[20];
    assign r15 = rf[21];
    assign r16 = rf[22];
    assign r17 = rf[23];
    assign r18 = rf[24];
    assign r19 = rf[25];
    assign r1A = rf[26];
    assign r1B = rf[27];
    assign r1C = rf[28];
    assign r1D = rf[29];
    assign r1E = rf[30];
    assign r1F = rf[31];
endmodule

// File: tb/tb_regfile_wr_2p.sv
// tb_regfile_wr_2p: directed table, corner sequences and random writes against an array model.
module tb_regfile_wr_2p;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic we0 = 1'b0, we1 = 1'b0;
    logic [4:0] wa0 = '0, wa1 = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic [31:0] rv [32];
    logic wrc;

    logic [31:0] m [32];
    logic ec;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wr_2p dut (
        .clk(clk), .rst(rst),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .r00(rv[0]),  .r01(rv[1]),  .r02(rv[2]),  .r03(rv[3]),
        .r04(rv[4]),  .r05(rv[5]),  .r06(rv[6]),  .r07(rv[7]),
        .r08(rv[8]),  .r09(rv[9]),  .r0A(rv[10]), .r0B(rv[11]),
        .r0C(rv[12]), .r0D(rv[13]), .r0E(rv[14]), .r0F(rv[15]),
        .r10(rv[16]), .r11(rv[17]), .r12(rv[18]), .r13(rv[19]),
        .r14(rv[20]), .r15(rv[21]), .r16(rv[22]), .r17(rv[23]),
        .r18(rv[24]), .r19(rv[25]), .r1A(rv[26]), .r1B(rv[27]),
        .r1C(rv[28]), .r1D(rv[29]), .r1E(rv[30]), .r1F(rv[31]),
        .wr_conflict(wrc)
    );

    typedef struct {
        logic we0; logic [4:0] wa0; logic [31:0] wd0;
        logic we1; logic [4:0] wa1; logic [31:0] wd1;
        int ca; logic [31:0] cv; logic cc;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) chk($sformatf("%s r%02h", tag, i), rv[i], m[i]);
        chk($sformatf("%s wr_conflict", tag), {31'b0, wrc}, {31'b0, ec});
    endtask

    task automatic drive(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic e1, input logic [4:0] a1, input logic [31:0] d1);
        we0 = e0; wa0 = a0; wd0 = d0; we1 = e1; wa1 = a1; wd1 = d1;
    endtask

    // Architectural rule: port 0 first, then port 1 overwrites; register 0 never changes.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst) ec = 1'b0;
        else begin
            ec = we0 && we1 && wa0 == wa1 && wa0 != 0;
            if (we0 && wa0 != 0) m[wa0] = wd0;
            if (we1 && wa1 != 0) m[wa1] = wd1;
        end
        #1;
        check_all(tag);
    endtask

    vec_t tbl [6];

    initial begin
        for (int i = 0; i < 32; i++) m[i] = '0;
        ec = 1'b0;
        tbl[0] = '{1'b1, 5'h07, 32'hDEAD_BEEF, 1'b0, 5'h00, 32'h0, 7, 32'hDEAD_BEEF, 1'b0};
        tbl[1] = '{1'b0, 5'h00, 32'h0, 1'b1, 5'h1F, 32'h0000_0001, 31, 32'h0000_0001, 1'b0};
        tbl[2] = '{1'b1, 5'h03, 32'hAAAA_AAAA, 1'b1, 5'h04, 32'h5555_5555, 4, 32'h5555_5555, 1'b0};
        tbl[3] = '{1'b1, 5'h09, 32'h1111_1111, 1'b1, 5'h09, 32'h2222_2222, 9, 32'h2222_2222, 1'b1};
        tbl[4] = '{1'b0, 5'h09, 32'h0, 1'b0, 5'h09, 32'h0, 9, 32'h2222_2222, 1'b0};
        tbl[5] = '{1'b1, 5'h00, 32'hFFFF_FFFF, 1'b1, 5'h00, 32'hFFFF_FFFF, 0, 32'h0, 1'b0};

        rst = 1'b1;
        #1;
        check_all("por");
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-cycle after preloading r05.
        drive(1'b1, 5'h05, 32'h1234_5678, 1'b0, 5'h00, 32'h0);
        cycle("preload");
        chk("preload r05", rv[5], 32'h1234_5678);
        drive(1'b0, 5'h00, 32'h0, 1'b0, 5'h00, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) m[i] = '0;
        ec = 1'b0;
        check_all("async_rst");
        // A write presented while rst is high is lost.
        drive(1'b1, 5'h06, 32'h0BAD_0BAD, 1'b0, 5'h00, 32'h0);
        cycle("rst_held");
        chk("rst_held r06", rv[6], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cycle("first_after_rst");
        chk("first_after_rst r06", rv[6], 32'h0BAD_0BAD);

        for (int k = 0; k < 6; k++) begin
            drive(tbl[k].we0, tbl[k].wa0, tbl[k].wd0, tbl[k].we1, tbl[k].wa1, tbl[k].wd1);
            cycle($sformatf("vec%0d", k));
            chk($sformatf("vec%0d reg", k), rv[tbl[k].ca], tbl[k].cv);
            chk($sformatf("vec%0d conflict", k), {31'b0, wrc}, {31'b0, tbl[k].cc});
        end
        chk("dual r03", rv[3], 32'hAAAA_AAAA);

        // No bypass: new data is invisible until the capturing edge.
        drive(1'b1, 5'h0A, 32'hCAFE_0000, 1'b0, 5'h00, 32'h0);
        #1;
        chk("nobypass before", rv[10], 32'h0);
        cycle("nobypass");
        chk("nobypass after", rv[10], 32'hCAFE_0000);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] a0, a1;
            a0 = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
            drive(1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom);
            cycle($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
